// File: rtl/product_streamer.sv
// Streams pixel x weight products for one layer pass, one neuron at a time,
// handing each neuron's NPIXEL products to an external accumulator.
//
// state     | meaning
// IDLE      | waiting for start
// STREAM    | issuing pixel/weight addresses, one pair per cycle
// DRAIN     | two cycles letting the ROM/product pipeline empty
// WAIT_BIAS | holding until the accumulator signals add_bias
module product_streamer #(
  parameter int NWBITS      = 16,
  parameter int NPIXEL      = 784,
  parameter int COUNT_BIT1  = 10,
  parameter int PIXEL_BITS  = 8,
  parameter int NNEURON     = 10,
  parameter int NEURON_BITS = 4,
  parameter int WADDR_BITS  = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [COUNT_BIT1-1:0]  pixel_addr,
  input  logic [PIXEL_BITS-1:0]  pixel_data,
  output logic [WADDR_BITS-1:0]  weight_addr,
  input  logic [NWBITS-1:0]      weight_data,
  output logic                   start_multiply,
  output logic [NWBITS-1:0]      partial_product,
  input  logic                   add_bias,
  output logic [NEURON_BITS-1:0] neuron_idx,
  output logic                   busy,
  output logic                   done
);

  localparam logic [COUNT_BIT1-1:0]  LAST_PIXEL  = COUNT_BIT1'(NPIXEL - 1);
  localparam logic [NEURON_BITS-1:0] LAST_NEURON = NEURON_BITS'(NNEURON - 1);
  localparam logic [COUNT_BIT1-1:0]  PIX_ONE     = COUNT_BIT1'(1);
  localparam logic [WADDR_BITS-1:0]  W_ONE       = WADDR_BITS'(1);
  localparam logic [NEURON_BITS-1:0] N_ONE       = NEURON_BITS'(1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, WAIT_BIAS} state_t;

  state_t state, state_next;
  logic   drain_cnt;
  logic   last_pixel;

  // Pipeline tags: address issued -> ROM data present -> data captured -> product out.
  logic issue_q, first_q, load_q, load_first_q;
  logic [PIXEL_BITS-1:0] pixel_q;
  logic [NWBITS-1:0]     weight_q;

  logic [NWBITS+PIXEL_BITS-1:0]        w_ext, p_ext;
  logic signed [NWBITS+PIXEL_BITS-1:0] prod_full;
  logic                                prod_unused;

  assign last_pixel = (pixel_addr == LAST_PIXEL);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = STREAM;
      STREAM:    if (last_pixel) state_next = DRAIN;
      DRAIN:     if (drain_cnt == 1'b0) state_next = WAIT_BIAS;
      WAIT_BIAS: if (add_bias) state_next = (neuron_idx == LAST_NEURON) ? IDLE : STREAM;
      default:   state_next = IDLE;
    endcase
  end

  // weight_addr holds on the last pixel so the next neuron resumes at n*NPIXEL.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_addr  <= '0;
      weight_addr <= '0;
      neuron_idx  <= '0;
      drain_cnt   <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pixel_addr  <= '0;
            weight_addr <= '0;
            neuron_idx  <= '0;
          end
        end
        STREAM: begin
          if (last_pixel) begin
            pixel_addr <= '0;
            drain_cnt  <= 1'b1;
          end else begin
            pixel_addr  <= pixel_addr + PIX_ONE;
            weight_addr <= weight_addr + W_ONE;
          end
        end
        DRAIN: begin
          if (drain_cnt != 1'b0) drain_cnt <= 1'b0;
        end
        WAIT_BIAS: begin
          if (add_bias) begin
            if (neuron_idx == LAST_NEURON) begin
              neuron_idx <= '0;
              done       <= 1'b1;
            end else begin
              neuron_idx  <= neuron_idx + N_ONE;
              weight_addr <= weight_addr + W_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel is zero-extended; the product always fits in NWBITS+PIXEL_BITS signed bits.
  assign w_ext       = {{PIXEL_BITS{weight_q[NWBITS-1]}}, weight_q};
  assign p_ext       = {{NWBITS{1'b0}}, pixel_q};
  assign prod_full   = $signed(w_ext) * $signed(p_ext);
  assign prod_unused = ^prod_full[PIXEL_BITS-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_q         <= 1'b0;
      first_q         <= 1'b0;
      load_q          <= 1'b0;
      load_first_q    <= 1'b0;
      pixel_q         <= '0;
      weight_q        <= '0;
      start_multiply  <= 1'b0;
      partial_product <= '0;
    end else begin
      issue_q         <= (state == STREAM);
      first_q         <= (state == STREAM) && (pixel_addr == '0);
      load_q          <= issue_q;
      load_first_q    <= first_q;
      pixel_q         <= pixel_data;
      weight_q        <= weight_data;
      start_multiply  <= load_first_q;
      partial_product <= load_q ? prod_full[NWBITS+PIXEL_BITS-1:PIXEL_BITS] : '0;
    end
  end

endmodule

// File: tb/tb_product_streamer.sv
// Randomised bench for product_streamer: a small instance (4 pixels, 2 neurons)
// checked cycle by cycle, and a default-size instance checked with an accumulator model.
module tb_product_streamer;

  localparam int SNP = 4;
  localparam int SNN = 2;
  localparam int FNP = 784;
  localparam int FNN = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_s, add_bias_s, start_f, add_bias_f;
  logic [9:0]  pixel_addr_s, pixel_addr_f;
  logic [12:0] weight_addr_s, weight_addr_f;
  logic [7:0]  pixel_data_s, pixel_data_f;
  logic [15:0] weight_data_s, weight_data_f;
  logic [15:0] partial_product_s, partial_product_f;
  logic [3:0]  neuron_idx_s, neuron_idx_f;
  logic start_multiply_s, start_multiply_f, busy_s, busy_f, done_s, done_f;

  int pmem [0:1023];
  int wmem [0:8191];
  int seen [0:3];
  int checks = 0;
  int failures = 0;
  int done_cnt_f = 0;

  product_streamer #(.NPIXEL(SNP), .NNEURON(SNN)) u_small (
    .clk(clk), .reset(reset), .start(start_s),
    .pixel_addr(pixel_addr_s), .pixel_data(pixel_data_s),
    .weight_addr(weight_addr_s), .weight_data(weight_data_s),
    .start_multiply(start_multiply_s), .partial_product(partial_product_s),
    .add_bias(add_bias_s), .neuron_idx(neuron_idx_s),
    .busy(busy_s), .done(done_s)
  );

  product_streamer u_full (
    .clk(clk), .reset(reset), .start(start_f),
    .pixel_addr(pixel_addr_f), .pixel_data(pixel_data_f),
    .weight_addr(weight_addr_f), .weight_data(weight_data_f),
    .start_multiply(start_multiply_f), .partial_product(partial_product_f),
    .add_bias(add_bias_f), .neuron_idx(neuron_idx_f),
    .busy(busy_f), .done(done_f)
  );

  // Synchronous ROMs: data follows the address by one cycle.
  always @(posedge clk) begin
    pixel_data_s  <= 8'(pmem[pixel_addr_s]);
    weight_data_s <= 16'(wmem[weight_addr_s]);
    pixel_data_f  <= 8'(pmem[pixel_addr_f]);
    weight_data_f <= 16'(wmem[weight_addr_f]);
  end

  always @(negedge clk) if (done_f) done_cnt_f++;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Spec rule: floor((weight * pixel) / 2^PIXEL_BITS).
  function automatic int model_product(input int w, input int p);
    int prod;
    prod = w * p;
    return prod >>> 8;
  endfunction

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 1024; i++) pmem[i] = (mode == 0) ? 255 : int'($urandom_range(0, 255));
    for (int i = 0; i < 8192; i++) wmem[i] = (mode == 0) ? 256 : int'($urandom_range(0, 65535)) - 32768;
    if (mode == 2) begin
      pmem[0] = 255; wmem[0] = -32768;
      pmem[1] = 128; wmem[1] = 32767;
    end
  endtask

  // One neuron on the small instance; j counts cycles after the edge that started it.
  task automatic do_neuron_s(input int n, input bit hold, input bit stray, input int d);
    int k, exp_pa, exp_wa, exp_pp;
    for (int j = 0; j <= SNP + 2 + d; j++) begin
      @(negedge clk);
      k      = j - 3;
      exp_pa = (j < SNP) ? j : 0;
      exp_wa = (j < SNP) ? n * SNP + j : n * SNP + SNP - 1;
      exp_pp = (k >= 0 && k < SNP) ? model_product(wmem[n * SNP + k], pmem[k]) : 0;
      check_eq($sformatf("pixel_addr n%0d j%0d", n, j), int'(pixel_addr_s), exp_pa);
      check_eq($sformatf("weight_addr n%0d j%0d", n, j), int'(weight_addr_s), exp_wa);
      check_eq($sformatf("neuron_idx n%0d j%0d", n, j), int'(neuron_idx_s), n);
      check_eq($sformatf("busy n%0d j%0d", n, j), int'(busy_s), 1);
      check_eq($sformatf("done n%0d j%0d", n, j), int'(done_s), 0);
      check_eq($sformatf("start_multiply n%0d j%0d", n, j), int'(start_multiply_s), (j == 3) ? 1 : 0);
      check_eq($sformatf("partial_product n%0d j%0d", n, j), int'($signed(partial_product_s)), exp_pp);
      if (n == 0 && k >= 0 && k < SNP) seen[k] = int'($signed(partial_product_s));
      start_s    = hold;
      add_bias_s = 1'b0;
      if (stray && j < SNP) add_bias_s = 1'($urandom_range(0, 1));
      if (stray && j == SNP + 1) add_bias_s = 1'b1;
      if (j == SNP + 2 + d) add_bias_s = 1'b1;
    end
  endtask

  task automatic run_pass_s(input bit hold, input bit stray, input int dfix);
    @(negedge clk);
    check_eq("idle busy before start", int'(busy_s), 0);
    start_s    = 1'b1;
    add_bias_s = 1'b0;
    for (int n = 0; n < SNN; n++)
      do_neuron_s(n, hold, stray, (dfix >= 0) ? dfix : int'($urandom_range(0, 6)));
    @(negedge clk);
    check_eq("done pulse", int'(done_s), 1);
    check_eq("busy after pass", int'(busy_s), 0);
    check_eq("neuron_idx after pass", int'(neuron_idx_s), 0);
    check_eq("weight_addr after pass", int'(weight_addr_s), SNN * SNP - 1);
    check_eq("partial after pass", int'(partial_product_s), 0);
    start_s    = 1'b0;
    add_bias_s = 1'b0;
    @(negedge clk);
    check_eq("done single cycle", int'(done_s), 0);
    check_eq("no restart", int'(busy_s), 0);
  endtask

  task automatic reset_mid_pass();
    @(negedge clk);
    start_s = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      start_s = 1'b0;
    end
    check_eq("product 2 before reset", int'($signed(partial_product_s)), 255);
    reset      = 1'b1;
    start_s    = 1'b1;
    add_bias_s = 1'b1;
    @(negedge clk);
    check_eq("rst pixel_addr", int'(pixel_addr_s), 0);
    check_eq("rst weight_addr", int'(weight_addr_s), 0);
    check_eq("rst start_multiply", int'(start_multiply_s), 0);
    check_eq("rst partial_product", int'(partial_product_s), 0);
    check_eq("rst neuron_idx", int'(neuron_idx_s), 0);
    check_eq("rst busy", int'(busy_s), 0);
    check_eq("rst done", int'(done_s), 0);
    reset      = 1'b0;
    start_s    = 1'b0;
    add_bias_s = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle after reset", int'(busy_s), 0);
    check_eq("no flushed product", int'(partial_product_s), 0);
  endtask

  task automatic run_full();
    int t, dut_sum, exp_sum, extra_sm;
    done_cnt_f = 0;
    @(negedge clk);
    start_f = 1'b1;
    for (int n = 0; n < FNN; n++) begin
      t = 0;
      do begin
        @(negedge clk);
        start_f    = 1'b0;
        add_bias_f = 1'b0;
        t++;
      end while (!start_multiply_f && t < 3000);
      if (!start_multiply_f) begin
        check_eq($sformatf("full start_multiply timeout n%0d", n), 0, 1);
        return;
      end
      dut_sum = 0; exp_sum = 0; extra_sm = 0;
      for (int k = 0; k < FNP; k++) begin
        if (k > 0) begin
          @(negedge clk);
          if (start_multiply_f) extra_sm++;
        end
        dut_sum += int'($signed(partial_product_f));
        exp_sum += model_product(wmem[n * FNP + k], pmem[k]);
      end
      check_eq($sformatf("full sum n%0d", n), dut_sum, exp_sum);
      check_eq($sformatf("full extra start_multiply n%0d", n), extra_sm, 0);
      check_eq($sformatf("full neuron_idx n%0d", n), int'(neuron_idx_f), n);
      @(negedge clk);
      check_eq($sformatf("full window end n%0d", n), int'(partial_product_f), 0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      add_bias_f = 1'b1;
      @(negedge clk);
      add_bias_f = 1'b0;
    end
    check_eq("full done", int'(done_f), 1);
    check_eq("full weight_addr final", int'(weight_addr_f), FNN * FNP - 1);
    check_eq("full busy end", int'(busy_f), 0);
    repeat (3) @(negedge clk);
    check_eq("full done count", done_cnt_f, 1);
  endtask

  initial begin
    reset = 1'b1;
    start_s = 1'b0; add_bias_s = 1'b0;
    start_f = 1'b0; add_bias_f = 1'b0;
    fill_mem(0);
    repeat (3) @(negedge clk);
    check_eq("reset pixel_addr", int'(pixel_addr_s), 0);
    check_eq("reset weight_addr", int'(weight_addr_s), 0);
    check_eq("reset start_multiply", int'(start_multiply_s), 0);
    check_eq("reset partial_product", int'(partial_product_s), 0);
    check_eq("reset neuron_idx", int'(neuron_idx_s), 0);
    check_eq("reset busy", int'(busy_s), 0);
    check_eq("reset done", int'(done_s), 0);
    reset = 1'b0;

    run_pass_s(1'b0, 1'b0, 5);
    for (int k = 0; k < SNP; k++) check_eq($sformatf("all-255 product %0d", k), seen[k], 255);

    fill_mem(2);
    run_pass_s(1'b0, 1'b0, 2);
    check_eq("signed min weight", seen[0], -32640);
    check_eq("signed max weight", seen[1], 16383);

    fill_mem(0);
    reset_mid_pass();
    run_pass_s(1'b0, 1'b0, 5);
    for (int k = 0; k < SNP; k++) check_eq($sformatf("after reset product %0d", k), seen[k], 255);

    fill_mem(1);
    run_pass_s(1'b1, 1'b1, 3);
    for (int i = 0; i < 6; i++) begin
      fill_mem(1);
      run_pass_s(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    fill_mem(1);
    run_full();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
